// File: rtl/lib_fir_arb_pkg.sv
// Shared definitions for the FIR frame arbiter: FSM state encoding and the
// index-width helper used to size channel and FIFO pointers.
package lib_fir_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Width needed to index n entries; never returns less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lib_sync_fifo.sv
// Small synchronous FIFO holding in-flight frame tags. A push and a pop in the
// same cycle both take effect; a push while full and a pop while empty are
// ignored. Synchronous active-low reset empties the FIFO.
module lib_sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    import lib_fir_arb_pkg::*;

    localparam int AW = idx_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; explicit wrap keeps any DEPTH legal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage; contents are only meaningful while flagged non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/lib_fir_frame_arbiter.sv
// Round-robin frame arbiter feeding one shared FIR from NUM_CH AXI4-Stream
// sources. Whole frames are granted, a guard gap separates frames, and a tag
// FIFO remembers which source owns each frame so the FIR output can be
// attributed (f_chan). Optional per-source frame counters are enabled by
// defining LIB_FIR_ARB_FRAME_CNT_EN.
module lib_fir_frame_arbiter
    import lib_fir_arb_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DIN_BW       = 16,
    parameter int GUARD_CYCLES = 4,
    parameter int TAG_DEPTH    = 4
) (
    input  logic                       s_axis_aclk,
    input  logic                       s_axis_aresetn,
    input  logic [NUM_CH-1:0]          s_axis_tvalid,
    output logic [NUM_CH-1:0]          s_axis_tready,
    input  logic [NUM_CH-1:0]          s_axis_tlast,
    input  logic [NUM_CH*DIN_BW-1:0]   s_axis_tdata_real,
    input  logic [NUM_CH*DIN_BW-1:0]   s_axis_tdata_imag,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    output logic [DIN_BW-1:0]          m_axis_tdata_real,
    output logic [DIN_BW-1:0]          m_axis_tdata_imag,
    input  logic                       f_axis_tvalid,
    input  logic                       f_axis_tlast,
    output logic [$clog2(NUM_CH)-1:0]  f_chan,
    output logic                       err_tag
`ifdef LIB_FIR_ARB_FRAME_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]       frame_cnt
`endif
);

    localparam int CH_W = idx_w(NUM_CH);

    arb_state_t               state;
    arb_state_t               state_nxt;
    logic [CH_W-1:0]          grant;
    logic [CH_W-1:0]          rr_ptr;
    logic [CH_W-1:0]          pick;
    logic [CH_W:0]            idx;
    logic                     req_any;
    logic [7:0]               gap_cnt;
    logic                     gap_done;
    logic                     start;
    logic                     hs;
    logic                     hs_last;
    logic [NUM_CH-1:0]        ready;

    logic                     vld_p0;
    logic                     last_p0;
    logic signed [DIN_BW-1:0] re_p0;
    logic signed [DIN_BW-1:0] im_p0;

    logic [CH_W-1:0]          tag_head;
    logic                     tag_full;
    logic                     tag_empty;

    assign gap_done = (gap_cnt == 8'(GUARD_CYCLES-1));

    // Round-robin pick: the lowest offset from rr_ptr with a valid request wins.
    always_comb begin
        req_any = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NUM_CH)) begin
                idx = idx - (CH_W+1)'(NUM_CH);
            end
            if (s_axis_tvalid[idx[CH_W-1:0]]) begin
                req_any = 1'b1;
                pick    = idx[CH_W-1:0];
            end
        end
    end

    // Next-state and ready decode from registered state and grant.
    always_comb begin
        state_nxt = state;
        ready     = '0;
        start     = 1'b0;
        hs        = 1'b0;
        hs_last   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any && !tag_full) begin
                    start     = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                ready[grant] = 1'b1;
                hs           = s_axis_tvalid[grant];
                hs_last      = s_axis_tvalid[grant] & s_axis_tlast[grant];
                if (hs_last) begin
                    state_nxt = (GUARD_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_axis_tready = ready;

    // Control state: FSM, owner of the current frame, round-robin pointer, guard count.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                grant <= pick;
            end
            if (hs_last) begin
                rr_ptr <= (grant == CH_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
            end
            if (state == GAP) begin
                gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
            end
        end
    end

    // Output stage: one-cycle registered copy of each accepted beat; cleared on reset
    // so an abandoned frame never leaks a beat or a tlast.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            re_p0   <= '0;
            im_p0   <= '0;
        end else begin
            vld_p0  <= hs;
            last_p0 <= hs_last;
            if (hs) begin
                re_p0 <= $signed(s_axis_tdata_real[grant*DIN_BW +: DIN_BW]);
                im_p0 <= $signed(s_axis_tdata_imag[grant*DIN_BW +: DIN_BW]);
            end
        end
    end

    assign m_axis_tvalid     = vld_p0;
    assign m_axis_tlast      = last_p0;
    assign m_axis_tdata_real = re_p0;
    assign m_axis_tdata_imag = im_p0;

    lib_sync_fifo #(
        .WIDTH (CH_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .push      (start),
        .push_data (pick),
        .pop       (f_axis_tvalid & f_axis_tlast),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign f_chan = tag_empty ? '0 : tag_head;

    // Sticky flag: FIR produced output while no frame was outstanding.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            err_tag <= 1'b0;
        end else if (f_axis_tvalid && tag_empty) begin
            err_tag <= 1'b1;
        end
    end

`ifdef LIB_FIR_ARB_FRAME_CNT_EN
    // Per-source completed-frame counters, wrapping at 16 bits.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            frame_cnt <= '0;
        end else if (hs_last) begin
            frame_cnt[grant*16 +: 16] <= frame_cnt[grant*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lib_fir_frame_arbiter.sv
// Scoreboard bench for lib_fir_frame_arbiter (default parameters). Stimulus
// loads per-source beat queues and pushes the hand-ordered expected m_axis
// beats and FIR tags; monitors compare whenever the DUT presents a beat or the
// FIR strobes an end of frame.
module tb_lib_fir_frame_arbiter;

    localparam int NUM_CH       = 2;
    localparam int DIN_BW       = 16;
    localparam int GUARD_CYCLES = 4;
    localparam int TAG_DEPTH    = 4;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
        logic [7:0]  gap;
    } beat_t;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic [NUM_CH-1:0]         s_axis_tvalid;
    logic [NUM_CH-1:0]         s_axis_tready;
    logic [NUM_CH-1:0]         s_axis_tlast;
    logic [NUM_CH*DIN_BW-1:0]  s_axis_tdata_real;
    logic [NUM_CH*DIN_BW-1:0]  s_axis_tdata_imag;
    logic                      m_axis_tvalid;
    logic                      m_axis_tlast;
    logic [DIN_BW-1:0]         m_axis_tdata_real;
    logic [DIN_BW-1:0]         m_axis_tdata_imag;
    logic                      f_axis_tvalid;
    logic                      f_axis_tlast;
    logic [$clog2(NUM_CH)-1:0] f_chan;
    logic                      err_tag;
`ifdef LIB_FIR_ARB_FRAME_CNT_EN
    logic [NUM_CH*16-1:0]      frame_cnt;
`endif

    beat_t srcq [NUM_CH][$];
    beat_t expq [$];
    int    tagq [$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    lib_fir_frame_arbiter #(
        .NUM_CH       (NUM_CH),
        .DIN_BW       (DIN_BW),
        .GUARD_CYCLES (GUARD_CYCLES),
        .TAG_DEPTH    (TAG_DEPTH)
    ) dut (
        .s_axis_aclk       (clk),
        .s_axis_aresetn    (rstn),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tdata_real (s_axis_tdata_real),
        .s_axis_tdata_imag (s_axis_tdata_imag),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tdata_real (m_axis_tdata_real),
        .m_axis_tdata_imag (m_axis_tdata_imag),
        .f_axis_tvalid     (f_axis_tvalid),
        .f_axis_tlast      (f_axis_tlast),
        .f_chan            (f_chan),
        .err_tag           (err_tag)
`ifdef LIB_FIR_ARB_FRAME_CNT_EN
        ,
        .frame_cnt         (frame_cnt)
`endif
    );

    // Beat b (1-based) of frame frm from source src.
    function automatic beat_t mk_beat(input int src, input int frm, input int b,
                                      input int len, input int gap);
        beat_t x;
        x.re   = {4'(src), 4'(frm), 8'(b)};
        x.im   = {8'(b), 4'(frm), 4'(src)};
        x.last = (b == len);
        x.gap  = 8'(gap);
        return x;
    endfunction

    task automatic load_frame(input int src, input int frm, input int len,
                              input int gap_at, input int gap_len);
        for (int b = 1; b <= len; b++) begin
            srcq[src].push_back(mk_beat(src, frm, b, len, (b == gap_at) ? gap_len : 0));
        end
    endtask

    task automatic exp_frame(input int src, input int frm, input int len, input int upto);
        for (int b = 1; b <= upto; b++) begin
            expq.push_back(mk_beat(src, frm, b, len, 0));
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int t;
        t = 0;
        while (expq.size() != 0 && t < budget) begin
            @(posedge clk);
            #3;
            t++;
        end
        if (expq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout with %0d beats outstanding, required 0", nm, expq.size());
            expq.delete();
        end
    endtask

    task automatic fir_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            f_axis_tvalid = 1'b1;
            f_axis_tlast  = 1'b1;
            @(posedge clk);
            #1;
            f_axis_tvalid = 1'b0;
            f_axis_tlast  = 1'b0;
        end
    endtask

    // Source driver: advances a source's queue after each observed handshake.
    initial begin : driver
        logic [NUM_CH-1:0] hs;
        int                wait_cnt [NUM_CH];
        s_axis_tvalid     = '0;
        s_axis_tlast      = '0;
        s_axis_tdata_real = '0;
        s_axis_tdata_imag = '0;
        for (int k = 0; k < NUM_CH; k++) wait_cnt[k] = 0;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (hs[k] && srcq[k].size() > 0) begin
                    srcq[k].delete(0);
                    if (srcq[k].size() > 0) wait_cnt[k] = int'(srcq[k][0].gap);
                end
                if (wait_cnt[k] > 0) begin
                    wait_cnt[k]--;
                    s_axis_tvalid[k] = 1'b0;
                end else if (srcq[k].size() > 0) begin
                    s_axis_tvalid[k]                         = 1'b1;
                    s_axis_tlast[k]                          = srcq[k][0].last;
                    s_axis_tdata_real[k*DIN_BW +: DIN_BW]    = srcq[k][0].re;
                    s_axis_tdata_imag[k*DIN_BW +: DIN_BW]    = srcq[k][0].im;
                end else begin
                    s_axis_tvalid[k] = 1'b0;
                    s_axis_tlast[k]  = 1'b0;
                end
            end
        end
    end

    // Monitor: checks every m_axis beat and every FIR end-of-frame tag.
    initial begin : monitor
        beat_t e;
        int    t;
        forever begin
            @(negedge clk);
            if (m_axis_tvalid === 1'b1) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL m_axis_beat: got re=%h im=%h last=%b, required no beat",
                             m_axis_tdata_real, m_axis_tdata_imag, m_axis_tlast);
                end else begin
                    e = expq.pop_front();
                    if ({m_axis_tdata_real, m_axis_tdata_imag, m_axis_tlast} !== {e.re, e.im, e.last}) begin
                        n_err++;
                        $display("FAIL m_axis_beat: got re=%h im=%h last=%b, required re=%h im=%h last=%b",
                                 m_axis_tdata_real, m_axis_tdata_imag, m_axis_tlast, e.re, e.im, e.last);
                    end
                end
            end
            if (f_axis_tvalid === 1'b1 && f_axis_tlast === 1'b1) begin
                n_cmp++;
                if (tagq.size() == 0) begin
                    n_err++;
                    $display("FAIL f_chan: got %0d, required no outstanding frame", f_chan);
                end else begin
                    t = tagq.pop_front();
                    if (int'(f_chan) != t) begin
                        n_err++;
                        $display("FAIL f_chan: got %0d, required %0d", f_chan, t);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 20000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int seen;
        int done;
        int zeros;
        int cnt;
        rstn          = 1'b0;
        f_axis_tvalid = 1'b0;
        f_axis_tlast  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_m_data", {m_axis_tdata_real, m_axis_tdata_imag}, 0);
        chk("rst_f_chan", f_chan, 0);
        chk("rst_err_tag", err_tag, 0);
        rstn = 1'b1;

        // Single 3-beat frame from src0, then measure the idle gap before src1
        load_frame(0, 1, 3, 0, 0);
        exp_frame(0, 1, 3, 3);
        tagq.push_back(0);
        seen = 0;
        for (int t = 0; t < 100 && seen == 0; t++) begin
            @(posedge clk);
            #2;
            if (m_axis_tvalid && m_axis_tlast) seen = 1;
        end
        chk("t1_tlast_seen", seen, 1);
        load_frame(1, 2, 1, 0, 0);
        exp_frame(1, 2, 1, 1);
        tagq.push_back(1);
        zeros = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (s_axis_tready != '0) break;
            zeros++;
        end
        chk("t1_idle_cycles_after_tlast", zeros, GUARD_CYCLES + 1);
        wait_drain(100, "t1_drain");
        fir_pulses(2);

        // Both sources continuously valid, 5-beat frames: grants 0,1,0,1
        load_frame(0, 3, 5, 0, 0);
        load_frame(0, 4, 5, 0, 0);
        load_frame(1, 5, 5, 0, 0);
        load_frame(1, 6, 5, 0, 0);
        exp_frame(0, 3, 5, 5);
        exp_frame(1, 5, 5, 5);
        exp_frame(0, 4, 5, 5);
        exp_frame(1, 6, 5, 5);
        tagq.push_back(0);
        tagq.push_back(1);
        tagq.push_back(0);
        tagq.push_back(1);
        wait_drain(300, "t2_drain");
        fir_pulses(4);

        // src1 stalls two cycles before beat 3; src0 waits behind it
        load_frame(1, 7, 4, 3, 2);
        exp_frame(1, 7, 4, 4);
        tagq.push_back(1);
        seen  = 0;
        done  = 0;
        zeros = 0;
        for (int t = 0; t < 100 && done == 0; t++) begin
            @(posedge clk);
            #2;
            if (m_axis_tvalid) begin
                if (seen == 0) begin
                    seen = 1;
                    load_frame(0, 8, 1, 0, 0);
                    exp_frame(0, 8, 1, 1);
                    tagq.push_back(0);
                end
                if (m_axis_tlast) done = 1;
            end else if (seen != 0) begin
                zeros++;
            end
        end
        chk("t3_frame_done", done, 1);
        chk("t3_tvalid_gap", zeros, 2);
        wait_drain(100, "t3_drain");
        fir_pulses(2);

        // Five single-beat frames, no FIR output: fifth blocked by full tag FIFO
        load_frame(1, 9, 1, 0, 0);
        load_frame(1, 11, 1, 0, 0);
        load_frame(0, 10, 1, 0, 0);
        load_frame(0, 12, 1, 0, 0);
        load_frame(0, 13, 1, 0, 0);
        exp_frame(1, 9, 1, 1);
        exp_frame(0, 10, 1, 1);
        exp_frame(1, 11, 1, 1);
        exp_frame(0, 12, 1, 1);
        exp_frame(0, 13, 1, 1);
        tagq.push_back(1);
        tagq.push_back(0);
        tagq.push_back(1);
        tagq.push_back(0);
        tagq.push_back(0);
        for (int t = 0; t < 200 && expq.size() > 1; t++) begin
            @(posedge clk);
            #3;
        end
        chk("t4_four_frames_out", expq.size(), 1);
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #2;
            if (m_axis_tvalid) cnt++;
        end
        chk("t4_fifth_blocked", cnt, 0);
        fir_pulses(1);
        wait_drain(100, "t4_drain");
        fir_pulses(4);

        // Reset during beat 2 of a 6-beat src1 frame
        load_frame(1, 14, 6, 0, 0);
        exp_frame(1, 14, 6, 1);
        seen = 0;
        for (int t = 0; t < 100 && seen == 0; t++) begin
            @(posedge clk);
            #2;
            if (m_axis_tvalid) seen = 1;
        end
        chk("t6_beat1_seen", seen, 1);
        rstn = 1'b0;
        @(posedge clk);
        #2;
        srcq[0].delete();
        srcq[1].delete();
        chk("t6_rst_tready", s_axis_tready, 0);
        chk("t6_rst_m_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_m_tlast", m_axis_tlast, 0);
        chk("t6_rst_m_data", {m_axis_tdata_real, m_axis_tdata_imag}, 0);
        chk("t6_rst_f_chan", f_chan, 0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        load_frame(0, 15, 1, 0, 0);
        load_frame(1, 1, 1, 0, 0);
        exp_frame(0, 15, 1, 1);
        exp_frame(1, 1, 1, 1);
        tagq.push_back(0);
        tagq.push_back(1);
        wait_drain(100, "t6_drain");
        fir_pulses(2);

        // FIR output with no outstanding frame sets a sticky error
        repeat (8) @(posedge clk);
        #2;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        chk("t5_err_after_reset", err_tag, 0);
        f_axis_tvalid = 1'b1;
        @(posedge clk);
        #2;
        f_axis_tvalid = 1'b0;
        chk("t5_err_set", err_tag, 1);
        repeat (5) @(posedge clk);
        #2;
        chk("t5_err_sticky", err_tag, 1);
        rstn = 1'b0;
        @(posedge clk);
        #2;
        chk("t5_err_cleared", err_tag, 0);
        rstn = 1'b1;

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
